// File: rtl/cpu_core_mc.sv
// Multi-cycle accumulator CPU: A/B registers, ALU, Z/N/C/V flags, PC with conditional jumps.
// Latency: 2 cycles per instruction (FETCH+EXEC) plus one cycle per instruction-memory wait state.
// Backpressure: imem_req holds with a stable imem_addr until imem_ack; ack outside FETCH is ignored.
module cpu_core_mc #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int OPC_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [PC_W-1:0]           imem_addr,
    output logic                      imem_req,
    input  logic                      imem_ack,
    input  logic [OPC_W+DATA_W:0]     imem_data,
    output logic [DATA_W-1:0]         reg_a,
    output logic [DATA_W-1:0]         reg_b,
    output logic [3:0]                flags,
    output logic [DATA_W-1:0]         alu_out,
    output logic                      retired,
    output logic                      halted
);
    localparam int INSTR_W = OPC_W + 1 + DATA_W;
    localparam int MSB     = DATA_W - 1;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;
    typedef enum logic [3:0] {
        ALU_NONE, ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
    } alu_op_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]          flags_q, flags_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                imem_req_q, imem_req_d;
    logic                retired_q, retired_d;
    logic                halted_q, halted_d;

    // Instruction fields; the reserved bit between opcode and K carries no meaning
    logic [OPC_W-1:0]    opc;
    logic [DATA_W-1:0]   k;
    logic                rsv_unused;
    assign opc        = ir_q[INSTR_W-1 -: OPC_W];
    assign k          = ir_q[DATA_W-1:0];
    assign rsv_unused = ir_q[DATA_W];

    // Decoded controls
    int                  op_i;
    int                  grp;
    logic [1:0]          sub;
    alu_op_t             alu_op;
    logic [DATA_W-1:0]   x, y;
    logic                wr_a, wr_b, wr_f, jmp, is_hlt;

    // ALU results
    logic [DATA_W-1:0]   res;
    logic [DATA_W:0]     wide;
    logic                c_new, v_new;

    // Decode: opcodes 0x00-0x23 come in groups of four sharing one operation;
    // binary groups are {A=A op B, B=B op A, A=A op K, B=B op K},
    // unary groups are {A=f(A), A=f(B), B=f(A), B=f(B)}
    always_comb begin
        op_i   = int'(opc);
        grp    = op_i >> 2;
        sub    = opc[1:0];
        alu_op = ALU_NONE;
        x      = a_q;
        y      = b_q;
        wr_a   = 1'b0;
        wr_b   = 1'b0;
        wr_f   = 1'b0;
        jmp    = 1'b0;
        is_hlt = 1'b0;
        if (op_i <= 32'h13 || (op_i >= 32'h18 && op_i <= 32'h1B)) begin
            x    = sub[0] ? b_q : a_q;
            y    = sub[1] ? k : (sub[0] ? a_q : b_q);
            wr_a = !sub[0];
            wr_b = sub[0];
            wr_f = (grp != 0);
            case (grp)
                0:       alu_op = ALU_PASS;
                1:       alu_op = ALU_ADD;
                2:       alu_op = ALU_SUB;
                3:       alu_op = ALU_AND;
                4:       alu_op = ALU_OR;
                default: alu_op = ALU_XOR;
            endcase
        end else if (op_i <= 32'h23) begin
            x    = sub[0] ? b_q : a_q;
            wr_a = !sub[1];
            wr_b = sub[1];
            wr_f = 1'b1;
            case (grp)
                5:       alu_op = ALU_NOT;
                7:       alu_op = ALU_SHL;
                default: alu_op = ALU_SHR;
            endcase
        end else begin
            case (op_i)
                32'h24: begin x = b_q; y = DATA_W'(1); alu_op = ALU_ADD; wr_b = 1'b1; wr_f = 1'b1; end
                32'h25: begin x = a_q; y = b_q; alu_op = ALU_SUB; wr_f = 1'b1; end
                32'h26: begin x = a_q; y = k;   alu_op = ALU_SUB; wr_f = 1'b1; end
                32'h27: jmp = 1'b1;
                32'h28: jmp = flags_q[3];
                32'h29: jmp = !flags_q[3];
                32'h2A: jmp = flags_q[1];
                32'h2B: jmp = flags_q[2] ^ flags_q[0];
                32'h2D: is_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    // ALU: arithmetic carries out through the extra bit of wide; SUB carry is the borrow
    always_comb begin
        res   = '0;
        wide  = '0;
        c_new = 1'b0;
        v_new = 1'b0;
        case (alu_op)
            ALU_PASS: res = y;
            ALU_ADD: begin
                wide  = {1'b0, x} + {1'b0, y};
                res   = wide[MSB:0];
                c_new = wide[DATA_W];
                v_new = (x[MSB] == y[MSB]) && (res[MSB] != x[MSB]);
            end
            ALU_SUB: begin
                wide  = {1'b0, x} - {1'b0, y};
                res   = wide[MSB:0];
                c_new = wide[DATA_W];
                v_new = (x[MSB] != y[MSB]) && (res[MSB] != x[MSB]);
            end
            ALU_AND: res = x & y;
            ALU_OR:  res = x | y;
            ALU_XOR: res = x ^ y;
            ALU_NOT: res = ~x;
            ALU_SHL: begin res = {x[MSB-1:0], 1'b0}; c_new = x[MSB]; end
            ALU_SHR: begin res = {1'b0, x[MSB:1]};   c_new = x[0];   end
            default: ;
        endcase
    end

    // Next state: FETCH waits for ack, EXEC commits results, HALT freezes everything
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        flags_d    = flags_q;
        ir_d       = ir_q;
        imem_req_d = imem_req_q;
        retired_d  = 1'b0;
        halted_d   = halted_q;
        case (state_q)
            ST_FETCH: begin
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ack) begin
                    ir_d       = imem_data;
                    state_d    = ST_EXEC;
                    imem_req_d = 1'b0;
                    retired_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (wr_a) a_d = res;
                if (wr_b) b_d = res;
                if (wr_f) flags_d = {(res == '0), res[MSB], c_new, v_new};
                pc_d = jmp ? PC_W'(k) : pc_q + PC_W'(1);
                if (is_hlt) begin
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                    imem_req_d = 1'b0;
                end else begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                end
            end
            ST_HALT: imem_req_d = 1'b0;
            default: state_d = ST_FETCH;
        endcase
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            flags_q    <= '0;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            retired_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            flags_q    <= flags_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign reg_a     = a_q;
    assign reg_b     = b_q;
    assign flags     = flags_q;
    assign alu_out   = (state_q == ST_EXEC) ? res : '0;
    assign retired   = retired_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: directed programs, instruction memory with wait states,
// scoreboard of expected per-instruction results popped on each retired pulse.
module tb_cpu_core_mc;
    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  reg_a, reg_b, alu_out;
    logic [3:0]  flags;
    logic        retired, halted;

    cpu_core_mc #(.DATA_W(8), .PC_W(8), .OPC_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .reg_a(reg_a), .reg_b(reg_b), .flags(flags), .alu_out(alu_out),
        .retired(retired), .halted(halted)
    );

    typedef struct packed {
        logic [7:0] alu;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [7:0] pc;
        logic [7:0] gap;
        logic       h;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          wait_states = 0;
    int          stall_addr = -1;
    int          wcnt = 0;
    int          exp_run = 1;
    int          cyc = 0;
    int          last_ret = 0;
    int          run = 0;
    logic        mon_pend = 1'b0;
    logic        req_prev = 1'b0;
    logic [7:0]  addr_prev = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Instruction memory: acks after wait_states idle request cycles; stall_addr never acks
    initial begin
        imem_ack  = 1'b0;
        imem_data = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req && rst_n && int'(imem_addr) != stall_addr) begin
                if (wcnt >= wait_states) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: pops one expectation per retired pulse, checks alu_out then post-EXEC state
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_pend) begin
                chk("reg_a", 32'(reg_a), 32'(cur.a));
                chk("reg_b", 32'(reg_b), 32'(cur.b));
                chk("flags", 32'(flags), 32'(cur.f));
                chk("next_pc", 32'(imem_addr), 32'(cur.pc));
                chk("halted", 32'(halted), 32'(cur.h));
                mon_pend = 1'b0;
            end
            if (imem_req) begin
                if (req_prev) chk("addr_stable", 32'(imem_addr), 32'(addr_prev));
                run++;
            end else begin
                if (req_prev && exp_run != 0) chk("req_len", 32'(run), 32'(exp_run));
                run = 0;
            end
            req_prev  = imem_req;
            addr_prev = imem_addr;
            if (retired) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'(1), 32'(0));
                end else begin
                    cur = exp_q.pop_front();
                    chk("alu_out", 32'(alu_out), 32'(cur.alu));
                    if (cur.gap != 0) chk("retire_gap", 32'(cyc - last_ret), 32'(cur.gap));
                    mon_pend = 1'b1;
                end
                last_ret = cyc;
            end
        end
    end

    task automatic ins(input logic [7:0] addr, input logic [6:0] opc, input logic rsv,
                       input logic [7:0] k, input logic [7:0] e_alu, input logic [7:0] e_a,
                       input logic [7:0] e_b, input logic [3:0] e_f, input logic [7:0] e_pc,
                       input logic [7:0] gap);
        exp_t e;
        mem[addr] = {opc, rsv, k};
        e.alu = e_alu; e.a = e_a; e.b = e_b; e.f = e_f; e.pc = e_pc; e.gap = gap;
        e.h   = (opc == 7'h2D);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        stall_addr  = -1;
        wait_states = 0;
        exp_run     = 1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h5A00;  // HLT everywhere by default
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_halt_timeout"}, 32'(n < budget), 32'(1));
        repeat (2) @(negedge clk);
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'(0));
        chk("rst_addr", 32'(imem_addr), 32'(0));
        chk("rst_a", 32'(reg_a), 32'(0));
        chk("rst_b", 32'(reg_b), 32'(0));
        chk("rst_flags", 32'(flags), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_alu", 32'(alu_out), 32'(0));

        // 1: MOV A,5; ADD A,3
        do_reset();
        ins(8'h00, 7'h02, 1'b0, 8'h05, 8'h05, 8'h05, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h06, 1'b0, 8'h03, 8'h08, 8'h08, 8'h00, 4'b0000, 8'h02, 8'd2);
        ins(8'h02, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h08, 8'h00, 4'b0000, 8'h03, 8'd2);
        wait_halt("t1", 200);

        // 2: overflow/carry and logic/shift/INC flags
        do_reset();
        ins(8'h00, 7'h02, 1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h06, 1'b0, 8'h01, 8'h80, 8'h80, 8'h00, 4'b0101, 8'h02, 8'd2);
        ins(8'h02, 7'h02, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0101, 8'h03, 8'd2);
        ins(8'h03, 7'h06, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1010, 8'h04, 8'd2);
        ins(8'h04, 7'h03, 1'b0, 8'h05, 8'h05, 8'h00, 8'h05, 4'b1010, 8'h05, 8'd2);
        ins(8'h05, 7'h08, 1'b0, 8'h00, 8'hFB, 8'hFB, 8'h05, 4'b0110, 8'h06, 8'd2);
        ins(8'h06, 7'h16, 1'b0, 8'h00, 8'h04, 8'hFB, 8'h04, 4'b0000, 8'h07, 8'd2);
        ins(8'h07, 7'h18, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h04, 4'b0100, 8'h08, 8'd2);
        ins(8'h08, 7'h23, 1'b0, 8'h00, 8'h02, 8'hFF, 8'h02, 4'b0000, 8'h09, 8'd2);
        ins(8'h09, 7'h24, 1'b0, 8'h00, 8'h03, 8'hFF, 8'h03, 4'b0000, 8'h0A, 8'd2);
        ins(8'h0A, 7'h0E, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h03, 4'b0000, 8'h0B, 8'd2);
        ins(8'h0B, 7'h0F, 1'b0, 8'h30, 8'h00, 8'h0F, 8'h00, 4'b1000, 8'h0C, 8'd2);
        ins(8'h0C, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h0F, 8'h00, 4'b1000, 8'h0D, 8'd2);
        wait_halt("t2", 400);

        // 3: compares and conditional jumps, undefined opcode, reserved bit
        do_reset();
        ins(8'h00, 7'h02, 1'b0, 8'h10, 8'h10, 8'h10, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h26, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, 4'b1000, 8'h02, 8'd2);
        ins(8'h02, 7'h28, 1'b0, 8'h20, 8'h00, 8'h10, 8'h00, 4'b1000, 8'h20, 8'd2);
        ins(8'h20, 7'h29, 1'b0, 8'h40, 8'h00, 8'h10, 8'h00, 4'b1000, 8'h21, 8'd2);
        ins(8'h21, 7'h25, 1'b0, 8'h00, 8'h10, 8'h10, 8'h00, 4'b0000, 8'h22, 8'd2);
        ins(8'h22, 7'h2B, 1'b0, 8'h50, 8'h00, 8'h10, 8'h00, 4'b0000, 8'h23, 8'd2);
        ins(8'h23, 7'h26, 1'b0, 8'h20, 8'hF0, 8'h10, 8'h00, 4'b0110, 8'h24, 8'd2);
        ins(8'h24, 7'h2A, 1'b0, 8'h30, 8'h00, 8'h10, 8'h00, 4'b0110, 8'h30, 8'd2);
        ins(8'h30, 7'h2B, 1'b0, 8'h38, 8'h00, 8'h10, 8'h00, 4'b0110, 8'h38, 8'd2);
        ins(8'h38, 7'h50, 1'b0, 8'hAB, 8'h00, 8'h10, 8'h00, 4'b0110, 8'h39, 8'd2);
        ins(8'h39, 7'h03, 1'b1, 8'h77, 8'h77, 8'h10, 8'h77, 4'b0110, 8'h3A, 8'd2);
        ins(8'h3A, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h10, 8'h77, 4'b0110, 8'h3B, 8'd2);
        wait_halt("t3", 400);

        // 4: three wait states per fetch
        do_reset();
        wait_states = 3;
        exp_run     = 4;
        ins(8'h00, 7'h03, 1'b0, 8'h33, 8'h33, 8'h00, 8'h33, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h0B, 1'b0, 8'h34, 8'hFF, 8'h00, 8'hFF, 4'b0110, 8'h02, 8'd5);
        ins(8'h02, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 4'b0110, 8'h03, 8'd5);
        wait_halt("t4", 400);

        // 5: JCS both ways, SHL carry, JMP to 0xFF and PC wrap
        do_reset();
        ins(8'h00, 7'h2A, 1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h02, 1'b0, 8'h81, 8'h81, 8'h81, 8'h00, 4'b0000, 8'h02, 8'd2);
        ins(8'h02, 7'h1C, 1'b0, 8'h00, 8'h02, 8'h02, 8'h00, 4'b0010, 8'h03, 8'd2);
        ins(8'h03, 7'h27, 1'b0, 8'hFF, 8'h00, 8'h02, 8'h00, 4'b0010, 8'hFF, 8'd2);
        ins(8'hFF, 7'h2C, 1'b0, 8'h00, 8'h00, 8'h02, 8'h00, 4'b0010, 8'h00, 8'd2);
        ins(8'h00, 7'h2A, 1'b0, 8'h40, 8'h00, 8'h02, 8'h00, 4'b0010, 8'h40, 8'd2);
        ins(8'h40, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h02, 8'h00, 4'b0010, 8'h41, 8'd2);
        wait_halt("t5", 400);

        // 6a: HLT is terminal
        do_reset();
        ins(8'h00, 7'h02, 1'b0, 8'h11, 8'h11, 8'h11, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h2D, 1'b0, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0000, 8'h02, 8'd2);
        wait_halt("t6", 200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hlt_halted", 32'(halted), 32'(1));
            chk("hlt_req", 32'(imem_req), 32'(0));
            chk("hlt_retired", 32'(retired), 32'(0));
            chk("hlt_addr", 32'(imem_addr), 32'(2));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("hlt_rst_halted", 32'(halted), 32'(0));
        chk("hlt_rst_addr", 32'(imem_addr), 32'(0));

        // 6b: reset while a fetch is stalled
        do_reset();
        stall_addr = 2;
        exp_run    = 0;
        ins(8'h00, 7'h02, 1'b0, 8'h11, 8'h11, 8'h11, 8'h00, 4'b0000, 8'h01, 8'd0);
        ins(8'h01, 7'h24, 1'b0, 8'h00, 8'h01, 8'h11, 8'h01, 4'b0000, 8'h02, 8'd2);
        n = 0;
        while ((exp_q.size() != 0 || mon_pend) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_timeout", 32'(n < 200), 32'(1));
        repeat (4) @(negedge clk);
        chk("stall_req", 32'(imem_req), 32'(1));
        chk("stall_addr", 32'(imem_addr), 32'(2));
        chk("stall_retired", 32'(retired), 32'(0));
        chk("stall_a", 32'(reg_a), 32'(8'h11));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(imem_addr), 32'(0));
        chk("midrst_req", 32'(imem_req), 32'(0));
        chk("midrst_a", 32'(reg_a), 32'(0));
        chk("midrst_b", 32'(reg_b), 32'(0));
        chk("midrst_flags", 32'(flags), 32'(0));
        chk("midrst_halted", 32'(halted), 32'(0));
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
